// File: rtl/interrupt_priority_encoder_6_to_3_pkg.sv
// Shared types, constants and helpers for the 6-to-3 interrupt priority encoder.
package interrupt_pkg;

  localparam int NUM_IRQ = 6;
  localparam logic [2:0] CODE_NONE = 3'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Lowest set bit wins; bit i maps to code i+1, empty vector gives CODE_NONE.
  function automatic logic [2:0] prio_encode(input logic [NUM_IRQ-1:0] v);
    logic [2:0] c;
    c = CODE_NONE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) c = 3'(i + 1);
    end
    return c;
  endfunction

  // In-service bit for a code is reversed: code c lands on bit [6-c].
  function automatic logic [NUM_IRQ-1:0] code_to_isr(input logic [2:0] c);
    logic [NUM_IRQ-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (c == 3'(NUM_IRQ - i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Pending bit for a code: code c lives on bit [c-1].
  function automatic logic [NUM_IRQ-1:0] code_to_pending(input logic [2:0] c);
    logic [NUM_IRQ-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (c == 3'(i + 1)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/interrupt_priority_encoder_6_to_3_if.sv
// Request/acknowledge bus between the IO/CPU side (master) and the encoder (slave).
interface interrupt_priority_encoder_6_to_3_if;
  import interrupt_pkg::*;

  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               inta;
  logic               eoi;
  logic               int_out;
  logic [2:0]         int_code;
  logic [NUM_IRQ-1:0] isr_out;
  logic               spurious;

  modport master (
    output irq_req, irq_mask, inta, eoi,
    input  int_out, int_code, isr_out, spurious
  );

  modport slave (
    input  irq_req, irq_mask, inta, eoi,
    output int_out, int_code, isr_out, spurious
  );

endinterface

// File: rtl/interrupt_priority_encoder_6_to_3_edge_latch.sv
// Rising-edge detector and pending latch, one independent slice per request line.
module irq_edge_latch
  import interrupt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_clr,
  output logic [NUM_IRQ-1:0] o_pending
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_bit
      logic r_prev;
      logic r_pending;
      logic w_rise;

      assign w_rise = i_irq[gi] & ~r_prev;

      // A fresh edge re-arms the line even when it is being cleared this cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_prev    <= 1'b0;
          r_pending <= 1'b0;
        end else begin
          r_prev    <= i_irq[gi];
          r_pending <= w_rise | (r_pending & ~i_clr[gi]);
        end
      end

      assign o_pending[gi] = r_pending;
    end
  endgenerate

endmodule

// File: rtl/interrupt_priority_encoder_6_to_3.sv
// Non-nested interrupt controller: selects, presents and tracks one interrupt at a time.
module interrupt_priority_encoder_6_to_3
  import interrupt_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
)
(
  input logic clk,
  input logic reset,
  interrupt_priority_encoder_6_to_3_if.slave bus
);

  localparam logic [7:0] TIMEOUT_L = 8'(ACK_TIMEOUT);

  irq_state_t         r_state, w_state_next;
  logic [7:0]         r_cnt, w_cnt_next, w_cnt_inc;
  logic               r_int_out, w_int_out_next;
  logic [2:0]         r_int_code, w_int_code_next;
  logic [NUM_IRQ-1:0] r_isr, w_isr_next;
  logic               r_spurious, w_spurious_next;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_eligible;

  irq_edge_latch u_latch (
    .clk       (clk),
    .reset     (reset),
    .i_irq     (bus.irq_req),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  assign w_eligible = w_pending & ~bus.irq_mask;
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  // Next-state and output decode; the mask only matters when choosing in IDLE.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_int_out_next  = r_int_out;
    w_int_code_next = r_int_code;
    w_isr_next      = r_isr;
    w_spurious_next = 1'b0;
    w_clr           = '0;
    case (r_state)
      IDLE: begin
        if (|w_eligible) begin
          w_int_code_next = prio_encode(w_eligible);
          w_int_out_next  = 1'b1;
          w_cnt_next      = 8'd0;
          w_state_next    = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.inta) begin
          w_clr          = code_to_pending(r_int_code);
          w_isr_next     = code_to_isr(r_int_code);
          w_int_out_next = 1'b0;
          w_state_next   = SERVICE;
        end else if (w_cnt_inc == TIMEOUT_L) begin
          // Abandon the request but keep it pending so it is offered again.
          w_int_out_next  = 1'b0;
          w_int_code_next = CODE_NONE;
          w_spurious_next = 1'b1;
          w_state_next    = IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          w_isr_next      = '0;
          w_int_code_next = CODE_NONE;
          w_state_next    = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_int_out  <= 1'b0;
      r_int_code <= CODE_NONE;
      r_isr      <= '0;
      r_spurious <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_int_out  <= w_int_out_next;
      r_int_code <= w_int_code_next;
      r_isr      <= w_isr_next;
      r_spurious <= w_spurious_next;
    end
  end

  assign bus.int_out  = r_int_out;
  assign bus.int_code = r_int_code;
  assign bus.isr_out  = r_isr;
  assign bus.spurious = r_spurious;

endmodule

// File: tb/tb_interrupt_priority_encoder_6_to_3.sv
// Directed and randomized bench for the 6-to-3 interrupt priority encoder.
module tb_interrupt_priority_encoder_6_to_3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interrupt_priority_encoder_6_to_3_if ifc ();

  interrupt_priority_encoder_6_to_3 #(.ACK_TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending set, one "current" interrupt and what it is doing.
  logic [5:0] m_prev = '0;
  logic [5:0] m_pend = '0;
  int         m_mode = 0;   // 0 nothing, 1 presented to CPU, 2 being serviced
  int         m_code = 0;
  int         m_wait = 0;   // presented cycles without acknowledge
  bit         m_spur = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [5:0] rise;
    logic [5:0] elig;
    int win;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_mode = 0; m_code = 0; m_wait = 0; m_spur = 1'b0;
      return;
    end
    rise   = ifc.irq_req & ~m_prev;
    m_spur = 1'b0;
    case (m_mode)
      0: begin
        elig = m_pend & ~ifc.irq_mask;
        win  = 0;
        for (int c = 6; c >= 1; c--) if (elig[c-1]) win = c;
        if (win != 0) begin m_mode = 1; m_code = win; m_wait = 0; end
      end
      1: begin
        if (ifc.inta) begin
          m_pend[m_code-1] = 1'b0;
          m_mode = 2;
        end else begin
          m_wait++;
          if (m_wait >= 255) begin m_spur = 1'b1; m_mode = 0; m_code = 0; end
        end
      end
      default: begin
        if (ifc.eoi) begin m_mode = 0; m_code = 0; end
      end
    endcase
    m_pend = m_pend | rise;
    m_prev = ifc.irq_req;
  endtask

  task automatic step();
    logic [5:0] e_isr;
    @(posedge clk);
    model_step();
    #1;
    e_isr = (m_mode == 2) ? 6'(7'd1 << (6 - m_code)) : 6'd0;
    check("int_out",  32'(ifc.int_out),  32'(m_mode == 1));
    check("int_code", 32'(ifc.int_code), 32'(m_code));
    check("isr_out",  32'(ifc.isr_out),  32'(e_isr));
    check("spurious", 32'(ifc.spurious), 32'(m_spur));
  endtask

  task automatic pulse_inta();
    ifc.inta = 1'b1; step(); ifc.inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    ifc.eoi = 1'b1; step(); ifc.eoi = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    int n;
    n = 0;
    while (ifc.int_out !== 1'b1 && n < 400) begin step(); n++; end
    n_checks++;
    assert (ifc.int_out === 1'b1) else begin
      n_errors++;
      $error("FAIL %s wait: int_out %b expected 1", tag, ifc.int_out);
    end
  endtask

  initial begin
    int hi;
    ifc.irq_req = 6'h3F; ifc.irq_mask = '0; ifc.inta = 1'b0; ifc.eoi = 1'b0;

    // 1: reset with all lines high, then edges seen on the first free cycle
    repeat (3) step();
    check("rst_int_out", 32'(ifc.int_out), 32'd0);
    check("rst_isr", 32'(ifc.isr_out), 32'd0);
    rst = 1'b0;
    step();
    check("rel_cyc1_int_out", 32'(ifc.int_out), 32'd0);
    step();
    check("rel_cyc2_int_out", 32'(ifc.int_out), 32'd1);
    check("rel_cyc2_code", 32'(ifc.int_code), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      wait_int("drain");
      check("drain_code", 32'(ifc.int_code), 32'(k));
      pulse_inta();
      check("drain_isr", 32'(ifc.isr_out), 32'(1 << (6 - k)));
      pulse_eoi();
    end
    $display("T1 reset/drain done");

    // 2: single source, code 3
    ifc.irq_req = 6'b000000; step();
    ifc.irq_req = 6'b000100;
    wait_int("t2");
    check("t2_code", 32'(ifc.int_code), 32'd3);
    pulse_inta();
    check("t2_isr", 32'(ifc.isr_out), 32'b001000);
    check("t2_int_low", 32'(ifc.int_out), 32'd0);
    pulse_eoi();
    check("t2_isr_clr", 32'(ifc.isr_out), 32'd0);
    check("t2_code_clr", 32'(ifc.int_code), 32'd0);
    $display("T2 single source done");

    // 3: simultaneous edges on bits 5 and 1
    ifc.irq_req = 6'b000000; step();
    ifc.irq_req = 6'b100010;
    wait_int("t3a");
    check("t3_first", 32'(ifc.int_code), 32'd2);
    pulse_inta(); pulse_eoi();
    wait_int("t3b");
    check("t3_second", 32'(ifc.int_code), 32'd6);
    pulse_inta();
    check("t3_isr", 32'(ifc.isr_out), 32'b000001);
    pulse_eoi();
    $display("T3 priority done");

    // 4: higher-priority edge while code 4 is in service
    ifc.irq_req = 6'b000000; step();
    ifc.irq_req = 6'b001000;
    wait_int("t4");
    check("t4_code", 32'(ifc.int_code), 32'd4);
    pulse_inta();
    ifc.irq_req = 6'b001001;
    repeat (5) begin
      step();
      check("t4_hold", 32'(ifc.int_out), 32'd0);
    end
    pulse_eoi();
    check("t4_eoi_gap", 32'(ifc.int_out), 32'd0);
    step();
    check("t4_after", 32'(ifc.int_out), 32'd1);
    check("t4_after_code", 32'(ifc.int_code), 32'd1);
    pulse_inta(); pulse_eoi();
    $display("T4 in-service edge done");

    // 5: acknowledge timeout, stray eoi in ASSERT, inta+eoi together, stray inta in IDLE
    ifc.irq_req = 6'b000000; step();
    ifc.irq_req = 6'b010000;
    wait_int("t5");
    hi = 1;
    pulse_eoi();
    check("t5_stray_eoi", 32'(ifc.int_code), 32'd5);
    if (ifc.int_out === 1'b1) hi++;
    while (ifc.spurious !== 1'b1 && hi < 400) begin
      step();
      if (ifc.int_out === 1'b1) hi++;
    end
    check("t5_spurious", 32'(ifc.spurious), 32'd1);
    check("t5_assert_cycles", 32'(hi), 32'd255);
    check("t5_spur_int_low", 32'(ifc.int_out), 32'd0);
    step();
    check("t5_spur_gone", 32'(ifc.spurious), 32'd0);
    check("t5_represent", 32'(ifc.int_out), 32'd1);
    ifc.inta = 1'b1; ifc.eoi = 1'b1; step(); ifc.inta = 1'b0; ifc.eoi = 1'b0;
    check("t5_inta_eoi_isr", 32'(ifc.isr_out), 32'b000010);
    pulse_eoi();
    check("t5_isr_clr", 32'(ifc.isr_out), 32'd0);
    pulse_inta();
    check("t5_stray_inta_int", 32'(ifc.int_out), 32'd0);
    check("t5_stray_inta_isr", 32'(ifc.isr_out), 32'd0);
    $display("T5 timeout/stray done");

    // 6: masking, then reset while in service
    ifc.irq_req = 6'b000000; step();
    ifc.irq_mask = 6'b000001;
    ifc.irq_req  = 6'b010001;
    wait_int("t6a");
    check("t6_masked_pick", 32'(ifc.int_code), 32'd5);
    pulse_inta();
    ifc.irq_mask = 6'b000000;
    pulse_eoi();
    wait_int("t6b");
    check("t6_unmasked_pick", 32'(ifc.int_code), 32'd1);
    pulse_inta();
    check("t6_isr", 32'(ifc.isr_out), 32'b100000);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_isr", 32'(ifc.isr_out), 32'd0);
    check("t6_rst_code", 32'(ifc.int_code), 32'd0);
    $display("T6 mask/reset done");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ifc.irq_req = ifc.irq_req ^ 6'(1 << $urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0) ifc.irq_mask = 6'($urandom);
      ifc.inta = (ifc.int_out && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 63) == 0);
      ifc.eoi  = ((ifc.isr_out != 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; ifc.inta = 1'b0; ifc.eoi = 1'b0;
    $display("Random phase done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
